bicubic_scan_ctrl: RTL and testbench

//  Scan sequencer for the bicubic upscaler. Walks every target pixel (tx,ty) in raster order.
//  Per pixel it derives the source position incrementally (DDA, no divider): integer part

---
 rtl/bicubic_scan_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_bicubic_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_scan_ctrl.sv
// Scan sequencer for the bicubic upscaler.
// Walks target pixels in raster order, derives the source position with an
// incremental DDA (integer part plus remainder over T-1), issues one job per
// pixel over valid/ready and raises done once every issued job has retired.
module bicubic_scan_ctrl #(
    parameter int IMG_W   = 100,
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  v0,
    input  logic [6:0]  h0,
    input  logic [4:0]  sw,
    input  logic [4:0]  sh,
    input  logic [5:0]  tw,
    input  logic [5:0]  th,
    output logic        job_valid,
    input  logic        job_ready,
    output logic [13:0] job_src,
    output logic [4:0]  job_ix,
    output logic [4:0]  job_iy,
    output logic [5:0]  job_rx,
    output logic [5:0]  job_ry,
    output logic        job_exx,
    output logic        job_exy,
    output logic [13:0] job_dst,
    input  logic        eng_done,
    output logic        busy,
    output logic        err,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam logic [3:0] MAX_Q = 4'(MAX_OUT);

    state_t      state;
    logic [6:0]  v0_q, h0_q;
    logic [4:0]  sw_q, sh_q;
    logic [5:0]  tw_q, th_q;
    logic [5:0]  tx, ty, rx, ry;
    logic [4:0]  ix, iy;
    logic [3:0]  outstanding;

    logic        fire, retire, row_end, last_pix, cfg_bad;
    logic [6:0]  rx_sum, ry_sum;
    logic [5:0]  nxt_tx, nxt_ty, nxt_rx, nxt_ry;
    logic [4:0]  nxt_ix, nxt_iy;
    logic [3:0]  out_next;
    logic [13:0] src_row, nxt_src, nxt_dst;

    // Next DDA position, outstanding count and job fields for the coming cycle
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        fire     = job_valid && job_ready;
        retire   = eng_done && (outstanding != 4'd0);
        row_end  = (tx == tw_q - 6'd1);
        last_pix = row_end && (ty == th_q - 6'd1);
        cfg_bad  = (sw_q < 5'd2) || (sh_q < 5'd2) ||
                   ({1'b0, sw_q} > tw_q) || ({1'b0, sh_q} > th_q);
        rx_sum   = {1'b0, rx} + 7'(sw_q) - 7'd1;
        ry_sum   = {1'b0, ry} + 7'(sh_q) - 7'd1;

        nxt_tx = tx;
        nxt_ix = ix;
        nxt_rx = rx;
        nxt_ty = ty;
        nxt_iy = iy;
        nxt_ry = ry;
        if (fire) begin
            if (row_end) begin
                nxt_tx = 6'd0;
                nxt_ix = 5'd0;
                nxt_rx = 6'd0;
                nxt_ty = ty + 6'd1;
                // SH<=TH bounds the step below T-1, so at most one carry
                if (ry_sum >= 7'(th_q) - 7'd1) begin
                    nxt_ry = 6'(ry_sum - (7'(th_q) - 7'd1));
                    nxt_iy = iy + 5'd1;
                end else begin
                    nxt_ry = 6'(ry_sum);
                end
            end else begin
                nxt_tx = tx + 6'd1;
                if (rx_sum >= 7'(tw_q) - 7'd1) begin
                    nxt_rx = 6'(rx_sum - (7'(tw_q) - 7'd1));
                    nxt_ix = ix + 5'd1;
                end else begin
                    nxt_rx = 6'(rx_sum);
                end
            end
        end

        // A retire landing in the same cycle as a fire cancels it out
        out_next = outstanding;
        if (fire && !retire) begin
            out_next = outstanding + 4'd1;
        end else if (!fire && retire) begin
            out_next = outstanding - 4'd1;
        end

        // ROM address wraps at 14 bits; the caller keeps the window inside the ROM
        src_row = 14'(v0_q) + 14'(nxt_iy);
        nxt_src = src_row * 14'(IMG_W) + 14'(h0_q) + 14'(nxt_ix);
        nxt_dst = 14'(nxt_ty) * 14'(tw_q) + 14'(nxt_tx);
    end

    // Scan FSM with registered outputs; job fields track the position being offered
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
        if (!rst_n) begin
            state       <= S_IDLE;
            v0_q        <= '0;
            h0_q        <= '0;
            sw_q        <= '0;
            sh_q        <= '0;
            tw_q        <= '0;
            th_q        <= '0;
            tx          <= '0;
            ty          <= '0;
            rx          <= '0;
            ry          <= '0;
            ix          <= '0;
            iy          <= '0;
            outstanding <= '0;
            job_valid   <= 1'b0;
            job_src     <= '0;
            job_ix      <= '0;
            job_iy      <= '0;
            job_rx      <= '0;
            job_ry      <= '0;
            job_exx     <= 1'b0;
            job_exy     <= 1'b0;
            job_dst     <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here update together from pre-edge values.
            outstanding <= out_next;
            tx          <= nxt_tx;
            ty          <= nxt_ty;
            rx          <= nxt_rx;
            ry          <= nxt_ry;
            ix          <= nxt_ix;
            iy          <= nxt_iy;
            job_src     <= nxt_src;
            job_ix      <= nxt_ix;
            job_iy      <= nxt_iy;
            job_rx      <= nxt_rx;
            job_ry      <= nxt_ry;
            job_exx     <= (nxt_rx == 6'd0);
            job_exy     <= (nxt_ry == 6'd0);
            job_dst     <= nxt_dst;
            done        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        v0_q  <= v0;
                        h0_q  <= h0;
                        sw_q  <= sw;
                        sh_q  <= sh;
                        tw_q  <= tw;
                        th_q  <= th;
                        tx    <= '0;
                        ty    <= '0;
                        rx    <= '0;
                        ry    <= '0;
                        ix    <= '0;
                        iy    <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cfg_bad) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        job_valid <= (out_next < MAX_Q);
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (fire && last_pix) begin
                        job_valid <= 1'b0;
                        state     <= S_DRAIN;
                    end else begin
                        job_valid <= (out_next < MAX_Q);
                    end
                end
                S_DRAIN: begin
                    if (outstanding == 4'd0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bicubic_scan_ctrl.sv
// Self-checking bench for bicubic_scan_ctrl: a table of scan configurations
// plus hand-written throttle and mid-scan reset sequences. Expected jobs come
// from a direct division model and are queued at START, then compared on fire.
module tb_bicubic_scan_ctrl;

    localparam int IMG_W   = 100;
    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, job_ready, eng_done;
    logic [6:0]  v0, h0;
    logic [4:0]  sw, sh;
    logic [5:0]  tw, th;
    logic        job_valid, job_exx, job_exy, busy, err, done;
    logic [13:0] job_src, job_dst;
    logic [4:0]  job_ix, job_iy;
    logic [5:0]  job_rx, job_ry;

    always #5 clk = ~clk;

    bicubic_scan_ctrl #(.IMG_W(IMG_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .v0(v0), .h0(h0), .sw(sw), .sh(sh), .tw(tw), .th(th),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_src(job_src), .job_ix(job_ix), .job_iy(job_iy),
        .job_rx(job_rx), .job_ry(job_ry), .job_exx(job_exx), .job_exy(job_exy),
        .job_dst(job_dst), .eng_done(eng_done),
        .busy(busy), .err(err), .done(done)
    );

    typedef struct packed {
        logic [13:0] src;
        logic [4:0]  ix;
        logic [4:0]  iy;
        logic [5:0]  rx;
        logic [5:0]  ry;
        logic        exx;
        logic        exy;
        logic [13:0] dst;
    } job_t;

    typedef struct {
        logic [6:0] v0, h0;
        logic [4:0] sw, sh;
        logic [5:0] tw, th;
        bit         bad;        // expected: config error, no jobs, no done
        int         ready_pct;
        int         delay;
    } cfg_t;

    job_t sb[$];
    int   due_q[$];
    int   cyc = 0, n_checks = 0, n_fail = 0, fires = 0, done_cnt = 0, held = 0;
    int   ready_pct = 100, eng_delay = 2;
    bit   auto_eng = 1'b1, stall_prev = 1'b0, expect_idle = 1'b0;
    job_t stall_job;
    cfg_t tbl[9];
    cfg_t c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic job_t cur_job();
        job_t j;
        j.src = job_src; j.ix = job_ix; j.iy = job_iy; j.rx = job_rx; j.ry = job_ry;
        j.exx = job_exx; j.exy = job_exy; j.dst = job_dst;
        return j;
    endfunction

    // Reference positions by plain division: ix*(TW-1)+rx == tx*(SW-1)
    task automatic push_jobs(input cfg_t k);
        job_t j;
        int ny, nx, iy, ry, ix, rx;
        for (int ty = 0; ty < int'(k.th); ty++) begin
            ny = ty * (int'(k.sh) - 1);
            iy = ny / (int'(k.th) - 1);
            ry = ny % (int'(k.th) - 1);
            for (int tx = 0; tx < int'(k.tw); tx++) begin
                nx = tx * (int'(k.sw) - 1);
                ix = nx / (int'(k.tw) - 1);
                rx = nx % (int'(k.tw) - 1);
                j.src = 14'((int'(k.v0) + iy) * IMG_W + int'(k.h0) + ix);
                j.ix  = 5'(ix);
                j.iy  = 5'(iy);
                j.rx  = 6'(rx);
                j.ry  = 6'(ry);
                j.exx = (rx == 0);
                j.exy = (ry == 0);
                j.dst = 14'(ty * int'(k.tw) + tx);
                sb.push_back(j);
            end
        end
    endtask

    // One cycle: called at a negedge, drives inputs, scores a fire, waits for next negedge
    task automatic step(input logic rdy, input logic edone);
        job_t j;
        job_t e;
        j = cur_job();
        job_ready = rdy;
        eng_done  = edone;
        if (stall_prev && job_valid) check("stall_hold", 64'(j), 64'(stall_job));
        if (expect_idle) begin
            check("valid_after_last", 64'(job_valid), 64'(0));
            expect_idle = 1'b0;
        end
        if (done) begin
            done_cnt++;
            check("done_drained", 64'(sb.size() + due_q.size()), 64'(0));
        end
        if (job_valid && rdy) begin
            fires++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_job: got dst=%0d expected no job (cycle %0d)", job_dst, cyc);
            end else begin
                e = sb.pop_front();
                check("job", 64'(j), 64'(e));
                if (sb.size() == 0) expect_idle = 1'b1;
            end
            if (auto_eng) due_q.push_back(cyc + eng_delay);
            else held++;
        end
        stall_prev = job_valid && !rdy;
        stall_job  = j;
        cyc++;
        @(negedge clk);
    endtask

    // Cycle with the engine model retiring jobs after eng_delay
    task automatic cycle();
        logic rdy, ed;
        rdy = ($urandom_range(99) < ready_pct);
        ed  = (due_q.size() > 0) && (due_q[0] <= cyc);
        if (ed) void'(due_q.pop_front());
        step(rdy, ed);
    endtask

    task automatic start_scan(input cfg_t k);
        v0 = k.v0; h0 = k.h0; sw = k.sw; sh = k.sh; tw = k.tw; th = k.th;
        ready_pct = k.ready_pct;
        eng_delay = k.delay;
        start = 1'b1;
        if (!k.bad) push_jobs(k);
        step(1'b0, 1'b0);
        start = 1'b0;
        // Scrambled inputs mid-scan must not disturb the latched config
        v0 = 7'($urandom); h0 = 7'($urandom); sw = 5'($urandom);
        sh = 5'($urandom); tw = 6'($urandom); th = 6'($urandom);
    endtask

    task automatic run_to_done(input int budget);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            cycle();
            n++;
        end
        if (done_cnt == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", budget);
        end else begin
            check("done_one_cycle", 64'(done), 64'(0));
            check("busy_after_done", 64'(busy), 64'(0));
            check("err_clear", 64'(err), 64'(0));
        end
    endtask

    task automatic run_cfg(input cfg_t k);
        int d0, f0;
        d0 = done_cnt;
        f0 = fires;
        start_scan(k);
        if (k.bad) begin
            step(1'b1, 1'b0);
            check("err_set", 64'(err), 64'(1));
            check("err_not_busy", 64'(busy), 64'(0));
            repeat (8) cycle();
            check("err_hold", 64'(err), 64'(1));
            check("err_no_done", 64'(done_cnt - d0), 64'(0));
            check("err_no_job", 64'(fires - f0), 64'(0));
        end else begin
            run_to_done(int'(k.tw) * int'(k.th) * 6 + 100);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0;
        //           v0   h0   sw  sh  tw  th  bad  rdy% dly
        tbl[0] = '{7'd0,   7'd0,   5'd4,  5'd2,  6'd7,  6'd2,  1'b0, 100, 2}; // T1
        tbl[1] = '{7'd10,  7'd5,   5'd2,  5'd2,  6'd3,  6'd3,  1'b0, 100, 2}; // T2
        tbl[2] = '{7'd3,   7'd7,   5'd5,  5'd3,  6'd9,  6'd6,  1'b0, 50,  3}; // T4 random ready
        tbl[3] = '{7'd0,   7'd0,   5'd6,  5'd4,  6'd6,  6'd4,  1'b0, 100, 5}; // S==T, throttled
        tbl[4] = '{7'd127, 7'd127, 5'd31, 5'd31, 6'd63, 6'd63, 1'b0, 80,  1}; // maximum sizes
        tbl[5] = '{7'd0,   7'd0,   5'd8,  5'd4,  6'd4,  6'd8,  1'b1, 100, 2}; // SW>TW
        tbl[6] = '{7'd0,   7'd0,   5'd4,  5'd1,  6'd8,  6'd8,  1'b1, 100, 2}; // SH<2
        tbl[7] = '{7'd2,   7'd2,   5'd3,  5'd5,  6'd4,  6'd4,  1'b1, 100, 2}; // SH>TH
        tbl[8] = '{7'd1,   7'd1,   5'd2,  5'd2,  6'd2,  6'd2,  1'b0, 70,  1}; // smallest

        rst_n = 1'b0; start = 1'b0; job_ready = 1'b0; eng_done = 1'b0;
        v0 = '0; h0 = '0; sw = '0; sh = '0; tw = '0; th = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({job_valid, busy, err, done}), 64'(0));
        check("rst_job", 64'(cur_job()), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_cfg(tbl[i]);

        // Throttle at MAX_OUT with retirement withheld; START mid-scan is ignored
        c = '{7'd0, 7'd0, 5'd2, 5'd2, 6'd3, 6'd3, 1'b0, 100, 2};
        start_scan(c);
        auto_eng = 1'b0;
        held     = 0;
        f0       = fires;
        repeat (4) step(1'b1, 1'b0);
        start = 1'b1; v0 = 7'd50; sw = 5'd9; tw = 6'd20;
        step(1'b1, 1'b0);
        start = 1'b0;
        repeat (5) step(1'b1, 1'b0);
        check("throttle_fires", 64'(fires - f0), 64'(MAX_OUT));
        check("throttle_valid", 64'(job_valid), 64'(0));
        check("throttle_busy", 64'(busy), 64'(1));
        step(1'b0, 1'b1);
        held--;
        check("unblock_valid", 64'(job_valid), 64'(1));
        step(1'b1, 1'b1);
        held--;
        check("same_cycle_keep", 64'(job_valid), 64'(1));
        step(1'b1, 1'b0);
        check("refill_block", 64'(job_valid), 64'(0));
        check("no_early_done", 64'(done), 64'(0));
        auto_eng = 1'b1;
        repeat (held) due_q.push_back(cyc);
        held = 0;
        run_to_done(200);

        // Mid-ISSUE reset, then a clean restart from the first pixel
        c = '{7'd1, 7'd2, 5'd5, 5'd5, 6'd10, 6'd10, 1'b0, 100, 3};
        start_scan(c);
        repeat (6) cycle();
        rst_n = 1'b0;
        sb.delete();
        due_q.delete();
        step(1'b0, 1'b0);
        stall_prev  = 1'b0;
        expect_idle = 1'b0;
        step(1'b0, 1'b0);
        check("midrst_ctrl", 64'({job_valid, busy, err, done}), 64'(0));
        rst_n = 1'b1;
        f0 = done_cnt;
        repeat (5) step(1'b1, 1'b0);
        check("midrst_no_done", 64'(done_cnt - f0), 64'(0));
        check("midrst_idle", 64'(busy), 64'(0));
        run_cfg(c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
